// File: rtl/pipeline_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : pipeline_pkg
//  Purpose  : Types and constants shared by the pipeline stage controllers.
//             Provides the MEM-stage access state encoding, the data word
//             width and the word-alignment mask.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package pipeline_pkg;

  localparam int WORD_W = 32;

  // Low address bits that must be zero for a word access.
  localparam logic [1:0] ALIGN_MASK = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } mem_state_t;

endpackage : pipeline_pkg
`default_nettype wire

// File: rtl/mem_timeout_counter.sv
`default_nettype none
// ============================================================================
//  Module   : mem_timeout_counter
//  Purpose  : Saturating wait-cycle counter for a memory handshake. Counts
//             cycles while enabled, never wraps (stops at LIMIT), and flags
//             the cycle in which the count equals LIMIT-1, i.e. the last
//             permitted wait cycle.
//  Ports    : clock   - clock, all state on posedge
//             reset   - synchronous active-high reset
//             clear   - synchronous clear of the count
//             enable  - count this cycle
//             expired - count == LIMIT-1
//  Revision : 1.0  initial release
// ============================================================================
module mem_timeout_counter #(
  parameter int LIMIT = 255
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(LIMIT + 1);
  localparam logic [CW-1:0] COUNT_MAX  = CW'(LIMIT);
  localparam logic [CW-1:0] COUNT_LAST = CW'(LIMIT - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      count <= '0;
    end else if (enable && (count != COUNT_MAX)) begin
      count <= count + CW'(1);
    end
  end

  assign expired = (count == COUNT_LAST);

endmodule : mem_timeout_counter
`default_nettype wire

// File: rtl/mem_access_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : mem_access_ctrl
//  Purpose  : MEM-stage data-memory access controller. Converts the held
//             EX/MEM MemRead/MemWrite request into a req/ack transaction on
//             a multi-cycle memory port, stalls the pipeline while the
//             access is in flight, returns load data and flags misaligned
//             or timed-out accesses.
//  Ports    : clock, reset            - clock / sync active-high reset
//             MemRead_in, MemWrite_in - request from EX/MEM
//             addr_in, wdata_in       - address / store data from EX/MEM
//             stall                   - 1 = pipeline registers hold
//             busy                    - controller not idle
//             mem_req, mem_we         - memory request / write select
//             mem_addr, mem_wdata     - memory address / store data
//             mem_ack, mem_rdata      - memory completion / read data
//             load_data, load_valid   - captured load data / load done pulse
//             align_fault             - misaligned request pulse
//             bus_error               - timeout pulse
//  Revision : 1.0  initial release
// ============================================================================
module mem_access_ctrl
  import pipeline_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              MemRead_in,
  input  logic              MemWrite_in,
  input  logic [WORD_W-1:0] addr_in,
  input  logic [WORD_W-1:0] wdata_in,
  output logic              stall,
  output logic              busy,
  output logic              mem_req,
  output logic              mem_we,
  output logic [WORD_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [WORD_W-1:0] mem_rdata,
  output logic [WORD_W-1:0] load_data,
  output logic              load_valid,
  output logic              align_fault,
  output logic              bus_error
);

  mem_state_t state;

  logic req_present;
  logic misaligned;
  logic start_access;
  logic tmo_enable;
  logic tmo_expired;

  assign req_present  = MemRead_in | MemWrite_in;
  assign misaligned   = |(addr_in[1:0] & ALIGN_MASK);
  assign start_access = (state == IDLE) && req_present && !misaligned;

  // Stall must rise in the same cycle the request is seen so EX/MEM keeps
  // the instruction; it drops in DONE so the stage advances exactly once.
  assign stall = start_access || (state == WAIT);

  assign tmo_enable = (state == WAIT) && !mem_ack;

  mem_timeout_counter #(
    .LIMIT(TIMEOUT_CYCLES)
  ) u_timeout (
    .clock  (clock),
    .reset  (reset),
    .clear  (start_access),
    .enable (tmo_enable),
    .expired(tmo_expired)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      busy        <= 1'b0;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      load_data   <= '0;
      load_valid  <= 1'b0;
      align_fault <= 1'b0;
      bus_error   <= 1'b0;
    end else begin
      // Status pulses last one cycle unless re-asserted below.
      load_valid  <= 1'b0;
      align_fault <= 1'b0;
      bus_error   <= 1'b0;

      case (state)
        IDLE: begin
          if (req_present) begin
            if (misaligned) begin
              align_fault <= 1'b1;
            end else begin
              mem_addr  <= addr_in;
              mem_wdata <= wdata_in;
              // A simultaneous read+write request is treated as a store.
              mem_we    <= MemWrite_in;
              mem_req   <= 1'b1;
              busy      <= 1'b1;
              state     <= WAIT;
            end
          end
        end

        WAIT: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            state   <= DONE;
            if (!mem_we) begin
              load_data  <= mem_rdata;
              load_valid <= 1'b1;
            end
          end else if (tmo_expired) begin
            mem_req   <= 1'b0;
            bus_error <= 1'b1;
            load_data <= '0;
            state     <= DONE;
          end
        end

        DONE: begin
          // Return to IDLE regardless of inputs: the same instruction is
          // still held in EX/MEM during this cycle and must not re-issue.
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          busy    <= 1'b0;
          mem_req <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule : mem_access_ctrl
`default_nettype wire

// File: tb/tb_mem_access_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_access_ctrl
//  Purpose  : Self-checking bench for mem_access_ctrl. Each transaction is
//             described by its request, address and the WAIT cycle on which
//             the memory acknowledges (0 = never); expected stall, request,
//             pulse and data behaviour is derived from those parameters.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mem_access_ctrl;

  localparam int T = 4;

  logic        clock;
  logic        reset;
  logic        MemRead_in;
  logic        MemWrite_in;
  logic [31:0] addr_in;
  logic [31:0] wdata_in;
  logic        stall;
  logic        busy;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic [31:0] load_data;
  logic        load_valid;
  logic        align_fault;
  logic        bus_error;

  int total = 0;
  int bad   = 0;

  // Model state: the value load_data should currently hold.
  logic [31:0] exp_load_data;

  logic [5:0] flags;
  assign flags = {stall, mem_req, busy, load_valid, bus_error, align_fault};

  mem_access_ctrl #(
    .TIMEOUT_CYCLES(T)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .MemRead_in (MemRead_in),
    .MemWrite_in(MemWrite_in),
    .addr_in    (addr_in),
    .wdata_in   (wdata_in),
    .stall      (stall),
    .busy       (busy),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata),
    .load_data  (load_data),
    .load_valid (load_valid),
    .align_fault(align_fault),
    .bus_error  (bus_error)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic drive_idle();
    MemRead_in  = 1'b0;
    MemWrite_in = 1'b0;
    addr_in     = $urandom;
    wdata_in    = $urandom;
    mem_ack     = 1'($urandom);
    mem_rdata   = $urandom;
  endtask

  // One cycle with no request. flags order: stall,req,busy,lv,be,af.
  task automatic idle_cycle(input string tag);
    drive_idle();
    @(negedge clock);
    total++;
    if (flags !== 6'b000000) begin
      bad++;
      $display("FAIL %s idle flags got=%b exp=%b", tag, flags, 6'b000000);
    end
    next_cycle();
  endtask

  // One complete access. ack_on = WAIT cycle (1..T) carrying mem_ack, 0 = none.
  task automatic run_access(input bit rd, input bit wr, input logic [31:0] addr,
                            input logic [31:0] wdata, input int ack_on,
                            input logic [31:0] rdata, input string tag);
    bit         mis;
    int         nwait;
    bit         exp_lv;
    bit         exp_be;
    logic [5:0] ef;
    mis    = (addr[1:0] != 2'b00);
    nwait  = (ack_on == 0) ? T : ack_on;
    exp_lv = rd && !wr && (ack_on != 0);
    exp_be = (ack_on == 0);

    MemRead_in  = rd;
    MemWrite_in = wr;
    addr_in     = addr;
    wdata_in    = wdata;
    mem_ack     = 1'($urandom);
    mem_rdata   = $urandom;
    @(negedge clock);

    if (mis) begin
      total++;
      if (flags !== 6'b000000) begin
        bad++;
        $display("FAIL %s misaligned request flags got=%b exp=%b", tag, flags, 6'b000000);
      end
      next_cycle();
      drive_idle();
      @(negedge clock);
      total++;
      if (flags !== 6'b000001) begin
        bad++;
        $display("FAIL %s align fault flags got=%b exp=%b", tag, flags, 6'b000001);
      end
      total++;
      if (load_data !== exp_load_data) begin
        bad++;
        $display("FAIL %s load_data after fault got=%h exp=%h", tag, load_data, exp_load_data);
      end
      next_cycle();
      return;
    end

    total++;
    if (flags !== 6'b100000) begin
      bad++;
      $display("FAIL %s request cycle flags got=%b exp=%b", tag, flags, 6'b100000);
    end
    next_cycle();

    for (int w = 1; w <= nwait; w++) begin
      mem_ack   = (w == ack_on);
      mem_rdata = (w == ack_on) ? rdata : $urandom;
      @(negedge clock);
      total++;
      if (flags !== 6'b111000) begin
        bad++;
        $display("FAIL %s wait%0d flags got=%b exp=%b", tag, w, flags, 6'b111000);
      end
      total++;
      if (mem_we !== wr || mem_addr !== addr) begin
        bad++;
        $display("FAIL %s wait%0d we/addr got=%b/%h exp=%b/%h", tag, w, mem_we, mem_addr, wr, addr);
      end
      if (wr) begin
        total++;
        if (mem_wdata !== wdata) begin
          bad++;
          $display("FAIL %s wait%0d wdata got=%h exp=%h", tag, w, mem_wdata, wdata);
        end
      end
      next_cycle();
    end

    if (exp_be) exp_load_data = 32'h0;
    else if (exp_lv) exp_load_data = rdata;

    mem_ack   = 1'($urandom);
    mem_rdata = $urandom;
    ef = {1'b0, 1'b0, 1'b1, exp_lv, exp_be, 1'b0};
    @(negedge clock);
    total++;
    if (flags !== ef) begin
      bad++;
      $display("FAIL %s done flags got=%b exp=%b", tag, flags, ef);
    end
    total++;
    if (load_data !== exp_load_data) begin
      bad++;
      $display("FAIL %s done load_data got=%h exp=%h", tag, load_data, exp_load_data);
    end
    next_cycle();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive_idle();
    mem_ack = 1'b1;
    next_cycle();
    next_cycle();
    @(negedge clock);
    total++;
    if (flags !== 6'b000000) begin
      bad++;
      $display("FAIL reset flags got=%b exp=%b", flags, 6'b000000);
    end
    total++;
    if (mem_we !== 1'b0 || mem_addr !== 32'h0 || mem_wdata !== 32'h0 || load_data !== 32'h0) begin
      bad++;
      $display("FAIL reset data got=%b/%h/%h/%h exp=0/0/0/0", mem_we, mem_addr, mem_wdata, load_data);
    end
    exp_load_data = 32'h0;
    next_cycle();
    reset   = 1'b0;
    mem_ack = 1'b1;   // stale ack in IDLE must be ignored
    idle_cycle("reset_stale_ack");
    idle_cycle("reset_idle");
  endtask

  task automatic test_load();
    run_access(1'b1, 1'b0, 32'h0000_0010, $urandom, 2, 32'hDEAD_BEEF, "load");
    idle_cycle("load_after");
  endtask

  task automatic test_store();
    run_access(1'b0, 1'b1, 32'h0000_0040, 32'h1234_5678, 1, $urandom, "store");
    idle_cycle("store_after");
  endtask

  task automatic test_read_write_both();
    run_access(1'b1, 1'b1, 32'h0000_0080, 32'hA5A5_0F0F, 3, 32'h5555_AAAA, "rw_both");
    idle_cycle("rw_both_after");
  endtask

  task automatic test_misaligned();
    run_access(1'b1, 1'b0, 32'h0000_0012, $urandom, 1, $urandom, "misaligned");
    idle_cycle("misaligned_after");
  endtask

  task automatic test_timeout();
    run_access(1'b1, 1'b0, 32'h0000_0100, $urandom, 0, $urandom, "timeout");
    idle_cycle("timeout_after");
  endtask

  task automatic test_reset_mid_wait();
    MemRead_in  = 1'b1;
    MemWrite_in = 1'b0;
    addr_in     = 32'h0000_0200;
    wdata_in    = $urandom;
    mem_ack     = 1'b0;
    next_cycle();                      // WAIT cycle 1
    next_cycle();                      // WAIT cycle 2
    reset = 1'b1;
    @(negedge clock);
    total++;
    if (flags !== 6'b111000) begin
      bad++;
      $display("FAIL rst_mid wait2 flags got=%b exp=%b", flags, 6'b111000);
    end
    next_cycle();
    reset       = 1'b0;
    MemRead_in  = 1'b0;
    mem_ack     = 1'b1;
    mem_rdata   = 32'hCAFE_F00D;
    exp_load_data = 32'h0;
    @(negedge clock);
    total++;
    if (flags !== 6'b000000) begin
      bad++;
      $display("FAIL rst_mid after flags got=%b exp=%b", flags, 6'b000000);
    end
    total++;
    if (mem_we !== 1'b0 || mem_addr !== 32'h0 || mem_wdata !== 32'h0 || load_data !== 32'h0) begin
      bad++;
      $display("FAIL rst_mid data got=%b/%h/%h/%h exp=0/0/0/0", mem_we, mem_addr, mem_wdata, load_data);
    end
    next_cycle();
    mem_ack = 1'b0;
    @(negedge clock);
    total++;
    if (flags !== 6'b000000 || load_data !== 32'h0) begin
      bad++;
      $display("FAIL rst_mid late_ack flags/data got=%b/%h exp=%b/%h", flags, load_data, 6'b000000, 32'h0);
    end
    next_cycle();
  endtask

  task automatic test_back_to_back();
    run_access(1'b1, 1'b0, 32'h0000_0300, $urandom, 1, 32'h1111_2222, "b2b_first");
    run_access(1'b1, 1'b0, 32'h0000_0304, $urandom, 2, 32'h3333_4444, "b2b_second");
    idle_cycle("b2b_after");
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      bit          rd;
      bit          wr;
      logic [31:0] addr;
      int          sel;
      sel = $urandom_range(0, 2);
      rd  = (sel != 1);
      wr  = (sel != 0);
      addr = $urandom;
      if ($urandom_range(0, 3) != 0) addr[1:0] = 2'b00;
      run_access(rd, wr, addr, $urandom, $urandom_range(0, T), $urandom, "random");
      for (int g = $urandom_range(0, 2); g > 0; g--) idle_cycle("random_gap");
    end
  endtask

  initial begin
    reset = 1'b1;
    exp_load_data = 32'h0;
    drive_idle();
    test_reset();
    test_load();
    test_store();
    test_read_write_both();
    test_misaligned();
    test_timeout();
    test_reset_mid_wait();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_mem_access_ctrl
`default_nettype wire
